// File: rtl/cmp_pkg.sv
// Types and constants shared by the serial signed comparator and its digit slice.
package cmp_pkg;

  localparam int OPERAND_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } result_t;

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned magnitude compare of one W-bit digit.
module cmp_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/comparator_32bit_signed_serial.sv
// Digit-serial signed 32-bit comparator, MSB-first, DIGIT_W bits per cycle.
// Define CMP_EARLY_EXIT_EN to finish the scan as soon as a differing digit is seen.
module comparator_32bit_signed_serial
  import cmp_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        lt,
  output logic        eq,
  output logic        gt
);

  localparam int NDIG  = OPERAND_W / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8)) begin : g_bad_digit_w
    $error("DIGIT_W must be 1, 2, 4 or 8");
  end

  state_t                 state_reg, state_next;
  logic [OPERAND_W-1:0]   a_sh_reg, b_sh_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   found_reg;
  logic                   lt_dec_reg;
  logic                   dig_lt, dig_gt;
  logic                   last_dig;
  result_t                res;

  // Operands are shifted left each cycle so the digit under test is always the top one.
  cmp_digit #(.W(DIGIT_W)) u_digit (
    .a  (a_sh_reg[OPERAND_W-1 -: DIGIT_W]),
    .b  (b_sh_reg[OPERAND_W-1 -: DIGIT_W]),
    .lt (dig_lt),
    .gt (dig_gt)
  );

  assign last_dig = (idx_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = SCAN;
      SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (last_dig || dig_lt || dig_gt) state_next = DONE;
`else
        if (last_dig) state_next = DONE;
`endif
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      idx_reg    <= '0;
      found_reg  <= 1'b0;
      lt_dec_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          // Flipping the sign bit maps two's complement order onto unsigned order.
          a_sh_reg   <= {~a[OPERAND_W-1], a[OPERAND_W-2:0]};
          b_sh_reg   <= {~b[OPERAND_W-1], b[OPERAND_W-2:0]};
          idx_reg    <= IDX_W'(NDIG - 1);
          found_reg  <= 1'b0;
          lt_dec_reg <= 1'b0;
        end
        SCAN: begin
          a_sh_reg <= a_sh_reg << DIGIT_W;
          b_sh_reg <= b_sh_reg << DIGIT_W;
          idx_reg  <= idx_reg - IDX_W'(1);
          if (!found_reg && (dig_lt || dig_gt)) begin
            found_reg  <= 1'b1;
            lt_dec_reg <= dig_lt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res    = '0;
    res.lt = found_reg && lt_dec_reg;
    res.gt = found_reg && !lt_dec_reg;
    res.eq = !found_reg;
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign lt        = out_valid && res.lt;
  assign eq        = out_valid && res.eq;
  assign gt        = out_valid && res.gt;

endmodule

// File: tb/tb_comparator_32bit_signed_serial.sv
// Scoreboard bench for comparator_32bit_signed_serial (DIGIT_W=4); honours CMP_EARLY_EXIT_EN.
module tb_comparator_32bit_signed_serial;

  localparam int DIGIT_W = 4;
  localparam int NDIG    = 32 / DIGIT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, lt, eq, gt;

  comparator_32bit_signed_serial #(.DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  res;   // {lt,eq,gt}
    int          lat;
    int          acc;
    int          hold;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: signed ordering by plain arithmetic; latency from first differing digit.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    int          l;
    d = x ^ y;
    l = NDIG;
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++)
      if (d[i]) l = (31 - i) / DIGIT_W + 1;
`endif
    return l;
  endfunction

  function automatic logic [2:0] exp_res(input logic [31:0] x, input logic [31:0] y);
    if ($signed(x) < $signed(y)) return 3'b100;
    if ($signed(x) > $signed(y)) return 3'b001;
    return 3'b010;
  endfunction

  // Issue one pair from a negedge; scramble operands during SCAN afterwards.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    int   w;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    e.res  = exp_res(x, y);
    e.lat  = exp_lat(x, y);
    e.acc  = cyc;
    e.hold = hold;
    e.x    = x;
    e.y    = y;
    sbq.push_back(e);
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    @(negedge clk);
  endtask

  // Monitor: pops on the first cycle of out_valid, then acts as the consumer.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        // nothing in flight during reset
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("result", int'({lt, eq, gt}), int'(e.res));
          chk("latency", cyc - e.acc, e.lat);
          chk("onehot", $countones({lt, eq, gt}), 1);
          for (int h = 0; h < e.hold; h++) begin
            @(negedge clk);
            chk("hold_result", int'({lt, eq, gt}), int'(e.res));
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          chk("handoff_out_valid", int'(out_valid), 0);
          $display("[TB] txn a=%08h b=%08h res(lt,eq,gt)=%03b lat=%0d hold=%0d",
                   e.x, e.y, e.res, e.lat, e.hold);
        end
      end else begin
        chk("idle_outputs_zero", int'({lt, eq, gt}), 0);
      end
    end
  end

  initial begin : driver
    int w;
    logic [31:0] x, y;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_results", int'({lt, eq, gt}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, first one issued immediately after reset release.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 0);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 0);
    issue(32'h7FFF_FFFF, 32'h8000_0000, 0);
    issue(32'h1234_5678, 32'h1234_5678, 0);
    issue(32'h1000_0000, 32'h2000_0000, 0);
    issue(32'h0000_0001, 32'h0000_0000, 5);
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1);

    // Reset in the middle of a scan: in-flight result is dropped.
    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    issue(32'hCAFE_0000, 32'hCAFE_0000, 0);
    rst = 1'b1;
    #1;
    chk("midscan_rst_in_ready", int'(in_ready), 1);
    chk("midscan_rst_out_valid", int'(out_valid), 0);
    void'(sbq.pop_back());
    @(negedge clk);
    rst = 1'b0;
    issue(32'd5, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ (32'h1 << $urandom_range(0, 31));
        default: y = $urandom;
      endcase
      issue(x, y, $urandom_range(0, 2));
    end

    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_scoreboard", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
